// File: rtl/atconv_pool_engine.sv
// atconv_pool_engine: 3x3 dilated conv with replicate pad, bias, ReLU/saturate, 2x2 max-pool with integer ceiling.
module atconv_pool_engine #(
  parameter int IMG_W = 64,
  parameter int DIL = 2,
  parameter int DW = 13,
  parameter int FRAC = 4,
  parameter logic [DW-1:0] BIAS = 13'h1FF4,
  localparam int LW = $clog2(IMG_W),
  localparam int AW = 2 * LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic          csel
);
  localparam int AX = DW + 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_CONV = 3'd1, S_L0WR = 3'd2, S_PLWR = 3'd3, S_DONE = 3'd4;
  localparam logic signed [AX-1:0] MAXP = AX'((1 << (DW - 1)) - 1);
  localparam logic signed [AX-1:0] BX = AX'($signed(BIAS));
  localparam logic [DW:0] FM = (DW + 1)'((1 << FRAC) - 1);
  localparam logic [DW-1:0] MAXI = DW'(((1 << (DW - 1)) - 1) & ~((1 << FRAC) - 1));
  localparam logic signed [LW+1:0] SD = (LW + 2)'(DIL);
  localparam logic signed [LW+1:0] WM = (LW + 2)'(IMG_W - 1);
  logic [2:0] state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [1:0] p_q, p_d;
  logic [AW-3:0] blk_q, blk_d;
  logic signed [AX-1:0] acc_q, acc_d;
  logic [DW-1:0] max_q, max_d, cdata_q, cdata_d, vs, pm, pool;
  logic busy_q, busy_d, done_q, done_d, cwr_q, cwr_d, csel_q, csel_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic [LW-1:0] r, c, row, col;
  logic [1:0] kr;
  logic [3:0] kc;
  logic signed [LW+1:0] tr, tc;
  logic signed [AX-1:0] xs, term, sum, v;
  logic [DW:0] up;
  // Pixel (r,c) walks 2x2 blocks in raster order, p selects the pixel inside the block
  assign r = {blk_q[AW-3:LW-1], p_q[1]};
  assign c = {blk_q[LW-2:0], p_q[0]};
  assign kr = k_q >= 4'd6 ? 2'd2 : k_q >= 4'd3 ? 2'd1 : 2'd0;
  assign kc = k_q - 4'(kr) * 4'd3;
  assign tr = kr == 2'd0 ? $signed({2'b0, r}) - SD : kr == 2'd2 ? $signed({2'b0, r}) + SD : $signed({2'b0, r});
  assign tc = kc == 4'd0 ? $signed({2'b0, c}) - SD : kc == 4'd2 ? $signed({2'b0, c}) + SD : $signed({2'b0, c});
  assign row = tr < 0 ? '0 : tr > WM ? LW'(IMG_W - 1) : tr[LW-1:0];
  assign col = tc < 0 ? '0 : tc > WM ? LW'(IMG_W - 1) : tc[LW-1:0];
  assign iaddr = {row, col};
  assign xs = {{4{idata[DW-1]}}, idata};
  assign term = (kr == 2'd1 && kc == 4'd1) ? xs
              : -(xs >>> ((kr != 2'd1 && kc != 4'd1) ? 4 : kr != 2'd1 ? 3 : 2));
  assign sum = acc_q + term;
  assign v = sum + BX;
  assign vs = v < 0 ? '0 : v > MAXP ? MAXP[DW-1:0] : v[DW-1:0];
  assign pm = max_q > cdata_q ? max_q : cdata_q;
  // Round a fractional max up to the next integer; clip to the largest representable integer
  assign up = ({1'b0, pm} + FM) & ~FM;
  assign pool = |up[DW:DW-1] ? MAXI : up[DW-1:0];
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    p_d = p_q;
    blk_d = blk_q;
    acc_d = acc_q;
    max_d = max_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cwr_d = 1'b0;
    csel_d = csel_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    case (state_q)
      S_IDLE: begin
        state_d = ready ? S_CONV : S_IDLE;
        busy_d = ready;
      end
      S_CONV: begin
        k_d = k_q == 4'd8 ? 4'd0 : k_q + 4'd1;
        acc_d = k_q == 4'd8 ? '0 : sum;
        if (k_q == 4'd8) begin
          state_d = S_L0WR;
          cwr_d = 1'b1;
          csel_d = 1'b0;
          caddr_d = {r, c};
          cdata_d = vs;
        end
      end
      S_L0WR: begin
        max_d = pm;
        state_d = p_q == 2'd3 ? S_PLWR : S_CONV;
        p_d = p_q == 2'd3 ? p_q : p_q + 2'd1;
        if (p_q == 2'd3) begin
          cwr_d = 1'b1;
          csel_d = 1'b1;
          caddr_d = {2'b0, blk_q};
          cdata_d = pool;
        end
      end
      S_PLWR: begin
        p_d = 2'd0;
        max_d = '0;
        blk_d = blk_q + 1'b1;
        state_d = &blk_q ? S_DONE : S_CONV;
        busy_d = ~&blk_q;
        done_d = &blk_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q <= '0;
      p_q <= '0;
      blk_q <= '0;
      acc_q <= '0;
      max_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cwr_q <= 1'b0;
      csel_q <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      p_q <= p_d;
      blk_q <= blk_d;
      acc_q <= acc_d;
      max_q <= max_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cwr_q <= cwr_d;
      csel_q <= csel_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign cwr = cwr_q;
  assign csel = csel_q;
  assign caddr_wr = caddr_q;
  assign cdata_wr = cdata_q;
endmodule
